// File: rtl/bus_fabric.sv
// Single-master bus interconnect: decodes the master address into NSLAVE regions,
// drives active-low chip selects, handles slave wait states and a timeout watchdog.
module bus_fabric #(
  parameter int AW      = 16,
  parameter int SAW     = 8,
  parameter int DW      = 16,
  parameter int NSLAVE  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_req,
  input  logic [AW-1:0]        m_addr,
  input  logic [DW-1:0]        m_wdata,
  input  logic                 m_rw_,
  output logic                 m_ack,
  output logic                 m_err,
  output logic [DW-1:0]        m_rdata,
  output logic                 busy,
  output logic [7:0]           err_cnt,
  output logic [SAW-1:0]       s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic                 s_rw_,
  output logic [NSLAVE-1:0]    s_cs_,
  input  logic [NSLAVE*DW-1:0] s_rdata,
  input  logic [NSLAVE-1:0]    s_ready
);

  localparam int IW = AW - SAW;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IW:0]   NSL      = (IW + 1)'(NSLAVE);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SAW-1:0]  s_addr_q, s_addr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic            s_rw_q, s_rw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_pend_q, err_pend_d;
  logic [DW-1:0]   m_rdata_q, m_rdata_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [DW-1:0]   sel_rdata;
  logic            sel_ready;
  logic            req_mapped;
  logic            timeout_hit;

  // Full-width index compare so unmapped regions never alias onto real slaves
  assign req_mapped  = {1'b0, m_addr[AW-1:SAW]} < NSL;
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (idx_q == IW'(i)) begin
        sel_rdata = s_rdata[i*DW +: DW];
        sel_ready = s_ready[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_req) state_d = req_mapped ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cs_ = '1;
    if (state_q == ACCESS) begin
      for (int i = 0; i < NSLAVE; i++) begin
        if (idx_q == IW'(i)) s_cs_[i] = 1'b0;
      end
    end
    m_ack = (state_q == RESP);
    m_err = (state_q == RESP) && err_pend_q;
    busy  = (state_q != IDLE);
  end

  always_comb begin
    idx_d      = idx_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_rw_d     = s_rw_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    m_rdata_d  = m_rdata_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          idx_d      = m_addr[AW-1:SAW];
          s_addr_d   = m_addr[SAW-1:0];
          s_wdata_d  = m_wdata;
          s_rw_d     = m_rw_;
          cnt_d      = '0;
          err_pend_d = !req_mapped;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // Ready takes priority over a coinciding timeout
        if (sel_ready) begin
          err_pend_d = 1'b0;
          if (s_rw_q) m_rdata_d = sel_rdata;
        end else if (timeout_hit) begin
          err_pend_d = 1'b1;
          if (s_rw_q) m_rdata_d = '0;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (err_pend_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_rw_q     <= 1'b1;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      m_rdata_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      idx_q      <= idx_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_rw_q     <= s_rw_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      m_rdata_q  <= m_rdata_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_rdata = m_rdata_q;
  assign err_cnt = err_cnt_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_rw_   = s_rw_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: randomized transfers against a transaction-level
// model, with a slave model that raises ready after a per-transfer wait count.
module tb_bus_fabric;
  localparam int AW = 16, SAW = 8, DW = 16, NS = 4, TO = 16;

  logic        clk = 0, reset = 1, m_req = 0;
  logic [15:0] m_addr = '0, m_wdata = '0;
  logic        m_rw_ = 1'b1;
  logic        m_ack, m_err, busy, s_rw_;
  logic [15:0] m_rdata, s_wdata;
  logic [7:0]  err_cnt, s_addr;
  logic [3:0]  s_cs_;
  logic [63:0] s_rdata = '0;
  logic [3:0]  s_ready = '0;

  bus_fabric #(.AW(AW), .SAW(SAW), .DW(DW), .NSLAVE(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rw_(m_rw_), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .busy(busy),
    .err_cnt(err_cnt), .s_addr(s_addr), .s_wdata(s_wdata), .s_rw_(s_rw_),
    .s_cs_(s_cs_), .s_rdata(s_rdata), .s_ready(s_ready));

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          mapped;
    bit          rw;
    logic [7:0]  saddr;
    logic [15:0] wdata;
    int          cs_cycles;
    int          ack_cyc;
    bit          err;
    logic [15:0] rdata;
    int          errcnt;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0;
  int          cyc = 0, cur_wait = 0, acc_cyc = 0, cs_cnt = 0;
  bit          abort_mode = 0;
  int          model_errcnt = 0;
  logic [15:0] model_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: the selected slave is ready once it has waited cur_wait cycles;
  // unselected ready lines toggle randomly and must be ignored.
  always @(posedge clk) begin
    logic [3:0] r;
    #2;
    r = 4'($urandom);
    if (s_cs_ !== 4'hF) begin
      acc_cyc++;
      for (int i = 0; i < NS; i++) if (s_cs_[i] === 1'b0) r[i] = (acc_cyc > cur_wait);
    end else begin
      acc_cyc = 0;
    end
    s_ready = r;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (s_cs_ !== 4'hF) begin
        if (sbq.size() == 0) begin
          if (!abort_mode) chk("cs_unexpected", 32'(s_cs_), 32'hF);
        end else begin
          cs_cnt++;
          chk("cs_pattern", 32'(s_cs_), 32'(4'hF & ~(4'b1 << sbq[0].idx)));
          chk("s_addr", 32'(s_addr), 32'(sbq[0].saddr));
          chk("s_wdata", 32'(s_wdata), 32'(sbq[0].wdata));
          chk("s_rw", 32'(s_rw_), 32'(sbq[0].rw));
        end
      end
      if (m_ack === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("ack_unexpected", 32'(m_ack), 32'h0);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
          chk("m_err", 32'(m_err), 32'(mon_e.err));
          chk("m_rdata", 32'(m_rdata), 32'(mon_e.rdata));
          chk("cs_cycles", 32'(cs_cnt), 32'(mon_e.cs_cycles));
          chk("err_cnt", 32'(err_cnt), 32'(mon_e.errcnt));
          cs_cnt = 0;
        end
      end else if (m_ack !== 1'b0) begin
        chk("ack_known", 32'(m_ack), 32'h0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    if (busy !== 1'b0) chk("idle_wait", 32'(busy), 32'h0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] wd, input logic rw,
                       input int w, input logic [15:0] rsel);
    exp_t        e;
    int          ix;
    logic [63:0] rd;
    wait_idle();
    ix       = int'(a[15:8]);
    rd       = {$urandom, $urandom};
    e.idx    = ix;
    e.mapped = (ix < NS);
    e.rw     = rw;
    e.saddr  = a[7:0];
    e.wdata  = wd;
    e.errcnt = model_errcnt;
    if (e.mapped) rd[ix*16 +: 16] = rsel;
    if (!e.mapped) begin
      e.cs_cycles = 0;
      e.err       = 1;
    end else if (w < TO) begin
      e.cs_cycles = w + 1;
      e.err       = 0;
      if (rw) model_rdata = rsel;
    end else begin
      e.cs_cycles = TO;
      e.err       = 1;
      if (rw) model_rdata = '0;
    end
    e.rdata = model_rdata;
    if (e.err && model_errcnt < 255) model_errcnt++;
    e.ack_cyc = cyc + 1 + e.cs_cycles;
    s_rdata   = rd;
    cur_wait  = w;
    sbq.push_back(e);
    m_req = 1; m_addr = a; m_wdata = wd; m_rw_ = rw;
    @(posedge clk); #1;
    m_req = 0; m_addr = 16'($urandom); m_wdata = 16'($urandom); m_rw_ = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hi;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", 32'(s_cs_), 32'hF);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_m_rdata", 32'(m_rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(m_ack), 32'h0);
    chk("rst_s_rw", 32'(s_rw_), 32'h1);
    reset = 0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_cs", 32'(s_cs_), 32'hF);

    issue(16'h0134, 16'h1111, 1'b1, 0, 16'hBEEF);
    issue(16'h0256, 16'hA5A5, 1'b0, 3, 16'h0000);
    issue(16'h0500, 16'h0000, 1'b1, 0, 16'h0000);
    issue(16'h000C, 16'h0000, 1'b1, 1000, 16'h1234);
    issue(16'h0077, 16'h0000, 1'b1, 15, 16'hCAFE);

    for (int n = 0; n < 150; n++) begin
      hi = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      issue({hi, 8'($urandom)}, 16'($urandom), 1'($urandom), int'($urandom_range(0, 20)),
            16'($urandom));
    end

    // Reset in the middle of an access: chip select must drop with no ack
    wait_idle();
    abort_mode = 1;
    cur_wait = 1000;
    m_req = 1; m_addr = 16'h0010; m_rw_ = 1'b1;
    @(posedge clk); #1;
    m_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_cs_low", 32'(s_cs_), 32'hE);
    reset = 1;
    #1;
    chk("abort_cs_release", 32'(s_cs_), 32'hF);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ack", 32'(m_ack), 32'h0);
    chk("abort_err_cnt", 32'(err_cnt), 32'h0);
    model_errcnt = 0;
    model_rdata  = '0;
    @(posedge clk);
    @(negedge clk) reset = 0;
    repeat (20) @(posedge clk);
    #1;
    abort_mode = 0;

    for (int n = 0; n < 260; n++) begin
      issue({8'($urandom_range(4, 255)), 8'($urandom)}, 16'($urandom), 1'($urandom), 0,
            16'h0000);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
